// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: word/byte loads and stores with a
// fixed number of wait states, stalling the pipeline until each access completes.
module dmem_responder #(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemWr_me,
   input  logic        sb_me,
   input  logic        rd_me,
   input  logic        lb_me,
   input  logic [31:0] Result_me,
   input  logic [31:0] busB_me,
   output logic [31:0] Dout,
   output logic        dout_valid,
   output logic        mem_stall,
   output logic        busy
);

   // state    | meaning
   // S_IDLE   | no access in flight; a request here is latched and stalls
   // S_WAIT   | counting wait states on the latched request
   // S_ACCESS | operation done on entry; pipeline advances this cycle

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   logic [1:0]              lane_q, lane_d;
   logic [31:0]             data_q, data_d;
   logic                    wr_q, wr_d;
   logic                    byte_q, byte_d;
   logic [31:0]             dout_q, dout_d;

   logic [31:0]             mem_q [DEPTH];

   logic                    req;
   logic [DEPTH_LOG2-1:0]   in_idx;
   logic                    op_fire;
   logic [DEPTH_LOG2-1:0]   op_idx;
   logic [1:0]              op_lane;
   logic [31:0]             op_data;
   logic                    op_wr;
   logic                    op_byte;
   logic [31:0]             rd_word;
   logic [7:0]              rd_byte;
   logic [31:0]             wr_word;
   logic                    mem_we;

   // Upper address bits are deliberately ignored so addresses wrap modulo depth.
   logic                    unused_addr;
   assign unused_addr = ^Result_me[31:DEPTH_LOG2+2];

   assign req    = MemWr_me | rd_me;
   assign in_idx = Result_me[DEPTH_LOG2+1:2];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      lane_d    = lane_q;
      data_d    = data_q;
      wr_d      = wr_q;
      byte_d    = byte_q;
      mem_stall = 1'b0;
      op_fire   = 1'b0;
      op_idx    = idx_q;
      op_lane   = lane_q;
      op_data   = data_q;
      op_wr     = wr_q;
      op_byte   = byte_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               mem_stall = 1'b1;
               idx_d     = in_idx;
               lane_d    = Result_me[1:0];
               data_d    = busB_me;
               wr_d      = MemWr_me;
               byte_d    = MemWr_me ? sb_me : lb_me;
               if (WAIT_CYCLES > 0) begin
                  cnt_d   = CNT_INIT;
                  state_d = S_WAIT;
               end else begin
                  // Zero wait states: operate straight from the live inputs.
                  state_d = S_ACCESS;
                  op_fire = 1'b1;
                  op_idx  = in_idx;
                  op_lane = Result_me[1:0];
                  op_data = busB_me;
                  op_wr   = MemWr_me;
                  op_byte = MemWr_me ? sb_me : lb_me;
               end
            end
         end
         S_WAIT: begin
            mem_stall = 1'b1;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_ACCESS;
               op_fire = 1'b1;
            end
         end
         S_ACCESS: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      rd_word = mem_q[op_idx];
      rd_byte = rd_word[{op_lane, 3'b000} +: 8];
      wr_word = rd_word;
      if (op_byte) begin
         wr_word[{op_lane, 3'b000} +: 8] = op_data[7:0];
      end else begin
         wr_word = op_data;
      end
   end

   // A reset arriving on the commit edge must not let the write through.
   assign mem_we = op_fire & op_wr & rst_n;

   always_comb begin
      dout_d = dout_q;
      if (op_fire && !op_wr) begin
         dout_d = op_byte ? {{24{rd_byte[7]}}, rd_byte} : rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         lane_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         byte_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         byte_q  <= byte_d;
         dout_q  <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[op_idx] <= wr_word;
      end
   end

   assign Dout       = dout_q;
   assign dout_valid = (state_q == S_ACCESS) & ~wr_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none,
// each checked every cycle against a transaction-level model of the memory.
module tb_dmem_responder;

   localparam int DL2   = 10;
   localparam int DEPTH = 1 << DL2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [2];
   logic        mw    [2];
   logic        sb    [2];
   logic        rd    [2];
   logic        lb    [2];
   logic [31:0] addr  [2];
   logic [31:0] data  [2];
   logic [31:0] dout  [2];
   logic        dv    [2];
   logic        ms    [2];
   logic        bz    [2];

   dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(2)) dut_w2 (
      .clk(clk), .rst_n(rst_n[0]), .MemWr_me(mw[0]), .sb_me(sb[0]), .rd_me(rd[0]),
      .lb_me(lb[0]), .Result_me(addr[0]), .busB_me(data[0]), .Dout(dout[0]),
      .dout_valid(dv[0]), .mem_stall(ms[0]), .busy(bz[0]));

   dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .rst_n(rst_n[1]), .MemWr_me(mw[1]), .sb_me(sb[1]), .rd_me(rd[1]),
      .lb_me(lb[1]), .Result_me(addr[1]), .busB_me(data[1]), .Dout(dout[1]),
      .dout_valid(dv[1]), .mem_stall(ms[1]), .busy(bz[1]));

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   logic        exp_stall [2];
   logic        exp_busy  [2];
   logic        exp_valid [2];
   logic [31:0] exp_dout  [2];
   logic [31:0] mdl_mem   [2][DEPTH];
   logic [31:0] fill      [2][16];
   logic [31:0] got;

   function automatic int wc(input int u);
      return (u == 0) ? 2 : 0;
   endfunction

   function automatic void check(input string name, input int u,
                                 input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s unit%0d: got %h want %h at %0t", name, u, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         for (int u = 0; u < 2; u++) begin
            check("mem_stall",  u, 32'(ms[u]), 32'(exp_stall[u]));
            check("busy",       u, 32'(bz[u]), 32'(exp_busy[u]));
            check("dout_valid", u, 32'(dv[u]), 32'(exp_valid[u]));
            check("Dout",       u, dout[u],    exp_dout[u]);
         end
      end
   end

   function automatic void drive(input int u, input bit w, input bit r, input bit s,
                                 input bit l, input logic [31:0] a, input logic [31:0] d);
      mw[u] = w; rd[u] = r; sb[u] = s; lb[u] = l; addr[u] = a; data[u] = d;
   endfunction

   function automatic void scramble(input int u);
      drive(u, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom, $urandom);
   endfunction

   function automatic void set_exp(input int u, input logic st, input logic b, input logic v);
      exp_stall[u] = st; exp_busy[u] = b; exp_valid[u] = v;
   endfunction

   task automatic idle(input int u, input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         drive(u, 0, 0, 0, 0, '0, '0);
         set_exp(u, 0, 0, 0);
      end
   endtask

   // One access: 1+WAIT stall cycles, then the ACCESS cycle. Inputs are randomised
   // after the request cycle since the responder must use its latched copy.
   task automatic do_access(input int u, input bit w, input bit r, input bit s, input bit l,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] res);
      int unsigned ix;
      int          lane;
      int          b;
      logic [31:0] word;
      logic [31:0] nd;
      bit          is_load;
      @(posedge clk); #1;
      drive(u, w, r, s, l, a, d);
      set_exp(u, 1, 0, 0);
      for (int k = 0; k < wc(u); k++) begin
         @(posedge clk); #1;
         scramble(u);
         set_exp(u, 1, 1, 0);
      end
      ix      = int'((a >> 2) % DEPTH);
      lane    = int'(a % 4);
      is_load = r && !w;
      nd      = exp_dout[u];
      word    = mdl_mem[u][ix];
      if (w) begin
         if (s) word = (word & ~(32'hFF << (8 * lane))) | ((d & 32'hFF) << (8 * lane));
         else   word = d;
         mdl_mem[u][ix] = word;
      end else if (l) begin
         b  = int'((word >> (8 * lane)) & 32'hFF);
         nd = (b >= 128) ? 32'(b - 256) : 32'(b);
      end else begin
         nd = word;
      end
      @(posedge clk); #1;
      scramble(u);
      set_exp(u, 0, 1, is_load);
      exp_dout[u] = nd;
      res = dout[u];
   endtask

   task automatic reset_mid_wait(input int u);
      @(posedge clk); #1;
      drive(u, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF);
      set_exp(u, 1, 0, 0);
      @(posedge clk); #1;
      drive(u, 0, 0, 0, 0, '0, '0);
      rst_n[u] = 1'b0;
      set_exp(u, 1, 1, 0);
      @(posedge clk); #1;
      set_exp(u, 0, 0, 0);
      exp_dout[u] = '0;
      @(posedge clk); #1;
      rst_n[u] = 1'b1;
      set_exp(u, 0, 0, 0);
   endtask

   task automatic random_phase(input int u, input int n);
      int          kind;
      bit          w, r, s, l;
      logic [31:0] a;
      for (int t = 0; t < n; t++) begin
         kind = int'($urandom_range(0, 5));
         a = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         s = 1'($urandom_range(0, 1));
         l = 1'($urandom_range(0, 1));
         case (kind)
            0:       begin w = 1; r = 0; s = 0; end
            1:       begin w = 1; r = 0; s = 1; end
            2:       begin w = 0; r = 1; l = 0; end
            3:       begin w = 0; r = 1; l = 1; end
            4:       begin w = 1; r = 1; end
            default: begin w = 0; r = 1; end
         endcase
         do_access(u, w, r, s, l, a, $urandom, got);
         idle(u, int'($urandom_range(0, 2)));
      end
      idle(u, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int u = 0; u < 2; u++) begin
         rst_n[u] = 1'b0;
         drive(u, 0, 0, 0, 0, '0, '0);
         set_exp(u, 0, 0, 0);
         exp_dout[u] = '0;
      end
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      idle(0, 1);
      idle(1, 1);

      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 16; i++) begin
            fill[u][i] = $urandom;
            do_access(u, 1, 0, 0, 0, 32'(i << 2), fill[u][i], got);
         end
         idle(u, 1);
      end

      reset_mid_wait(0);
      idle(0, 1);
      do_access(0, 0, 1, 0, 0, 32'h10, '0, got);
      check("lw_after_reset", 0, got, fill[0][4]);
      idle(0, 1);

      for (int u = 0; u < 2; u++) begin
         do_access(u, 1, 0, 0, 0, 32'h20, 32'h12345678, got);
         do_access(u, 0, 1, 0, 0, 32'h20, '0, got);
         check("lw_0x20", u, got, 32'h12345678);
         do_access(u, 1, 0, 1, 0, 32'h21, 32'h5A5A5AAB, got);
         do_access(u, 0, 1, 0, 0, 32'h20, '0, got);
         check("lw_after_sb", u, got, 32'h1234AB78);
         do_access(u, 0, 1, 0, 1, 32'h21, '0, got);
         check("lb_0x21", u, got, 32'hFFFFFFAB);
         do_access(u, 0, 1, 0, 1, 32'h20, '0, got);
         check("lb_0x20", u, got, 32'h00000078);
         do_access(u, 1, 1, 0, 0, 32'h1000, 32'h55, got);
         check("st_ld_both_hold", u, got, 32'h00000078);
         do_access(u, 0, 1, 0, 0, 32'h0, '0, got);
         check("lw_wrap", u, got, 32'h00000055);
         idle(u, 1);
      end

      do_access(1, 1, 0, 0, 0, 32'h24, 32'hCAFEF00D, got);
      idle(1, 1);
      do_access(1, 0, 1, 0, 0, 32'h20, '0, got);
      check("b2b_lw_0x20", 1, got, 32'h1234AB78);
      do_access(1, 0, 1, 0, 0, 32'h24, '0, got);
      check("b2b_lw_0x24", 1, got, 32'hCAFEF00D);
      idle(1, 1);

      random_phase(0, 150);
      random_phase(1, 150);
      idle(0, 2);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
